apb_rr_master_arbiter: RTL and testbench
========================================

// Module: apb_rr_master_arbiter
// PURPOSE
// Shares one APB master port between NUM_REQ requesters (CPU, DMA, debug) with round-robin arbitration.
// Each requester issues single transfers over a valid/ready request port and receives a one-cycle response pulse.
// Sequences the APB SETUP/ACCESS phases, honours slave wait states and aborts hung transfers with a timeout.
// Sits between bus masters and the APB interconnect that fans out to the simple APB slaves.
// PARAMETERS
// NUM_REQ     2                     number of requesters (>=1)
// ADDR_WIDTH  32                    APB address width
// DATA_WIDTH  32                    APB data width
// STRB_WIDTH  (DATA_WIDTH-1)/8+1    byte-strobe width
// TIMEOUT     16                    max ACCESS cycles with pready=0 before abort; 0 disables the timeout
// PORTS
// clk          in   1                     clock, all logic on posedge
// rstn         in   1                     asynchronous active-low reset
// req_valid    in   NUM_REQ               request valid, one bit per requester
// req_ready    out  NUM_REQ               request accepted this cycle (one-hot or zero)
// req_write    in   NUM_REQ               1=write, 0=read
// req_addr     in   NUM_REQ*ADDR_WIDTH    packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// req_wdata    in   NUM_REQ*DATA_WIDTH    packed write data
// req_strb     in   NUM_REQ*STRB_WIDTH    packed write strobes
// rsp_valid    out  NUM_REQ               one-cycle completion pulse to the owning requester
// rsp_rdata    out  DATA_WIDTH            read data, valid with rsp_valid
// rsp_err      out  1                     pslverr or timeout, valid with rsp_valid
// rsp_timeout  out  1                     transfer was aborted by timeout, valid with rsp_valid
// m_psel       out  1                     APB select
// m_penable    out  1                     APB enable
// m_pwrite     out  1                     APB direction
// m_paddr      out  ADDR_WIDTH            APB address
// m_pwdata     out  DATA_WIDTH            APB write data
// m_pstrb      out  STRB_WIDTH            APB strobes (all zero on reads)
// m_prdata     in   DATA_WIDTH            APB read data
// m_pready     in   1                     APB ready (wait states when low)
// m_pslverr    in   1                     APB slave error
// BEHAVIOUR
// - Reset (rstn=0, asynchronous): state=IDLE; all outputs 0; last_grant=NUM_REQ-1, so requester 0 has top priority first.
// - FSM states:
//   - IDLE: if any req_valid, pick the winner g, scanning from last_grant+1 upward with wrap.
//     req_ready[g]=1 combinationally in the same cycle; all other req_ready=0.
//     Latch addr/wdata/strb/write of g into the m_* registers; set last_grant=g; go to SETUP.
//     req_ready is 0 in every state other than IDLE.
//   - SETUP: m_psel=1, m_penable=0; always go to ACCESS next cycle.
//   - ACCESS: m_psel=1, m_penable=1; stay while m_pready=0.
//     On m_pready=1: capture m_prdata (reads; 0 on writes) and m_pslverr; go to IDLE.
// - Response: registered. rsp_valid[g]=1 for exactly the first IDLE cycle after ACCESS ends.
//   rsp_rdata, rsp_err and rsp_timeout are held until the next response.
// - Latency: accept in cycle T; SETUP T+1; ACCESS T+2; with zero wait states, rsp_valid at T+3.
//   A new accept may occur in T+3, giving a peak of one transfer per 3 cycles.
// - m_paddr, m_pwrite, m_pwdata and m_pstrb are stable from SETUP through the last ACCESS cycle.
//   They hold their value in IDLE until the next accept.
// - Timeout (TIMEOUT>0): a counter clears on entry to ACCESS and increments on each ACCESS cycle with m_pready=0.
//   - If m_pready=0 in the TIMEOUT-th ACCESS cycle, the transfer ends there: rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   - If m_pready=1 arrives in that same cycle, it wins and the transfer completes normally with no timeout.
// - A requester may drop req_valid before it is granted; nothing is recorded.
//   Its request fields are sampled only in its accept cycle.
// - A requester receiving rsp_valid may re-request in the same cycle.
//   It is then lowest priority whenever another requester is valid.
// - Reset mid-transfer aborts immediately: psel/penable drop asynchronously, and no rsp_valid is issued.
// TESTING
// 1. Single write req0 addr=0x10 wdata=0xA5A5 strb=0xF, pready=1
//    -> psel@T+1, penable@T+2, rsp_valid[0]@T+3, rsp_err=0.
// 2. req0 and req1 held valid continuously, 6 transfers -> grant order 0,1,0,1,0,1, one accept every 3 cycles.
// 3. Read req1 addr=0x20, pready low for 3 ACCESS cycles, prdata=0xDEADBEEF
//    -> paddr stable for 4 ACCESS cycles, rsp_rdata=0xDEADBEEF.
// 4. TIMEOUT=16, pready stuck low -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0.
// 5. pslverr=1 with pready=1 on a write -> rsp_err=1, rsp_timeout=0; next request proceeds normally.
// 6. rstn low during ACCESS -> psel/penable=0 without waiting for clk, no rsp_valid; after release, req0 wins first.

Source files
------------

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ valid/ready requesters.
// Sequences SETUP/ACCESS, honours wait states and aborts transfers that exceed TIMEOUT wait cycles.
module apb_rr_master_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = (DATA_WIDTH - 1) / 8 + 1,
   parameter int TIMEOUT    = 16
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_WIDTH-1:0]          rsp_rdata,
   output logic                           rsp_err,
   output logic                           rsp_timeout,
   output logic                           m_psel,
   output logic                           m_penable,
   output logic                           m_pwrite,
   output logic [ADDR_WIDTH-1:0]          m_paddr,
   output logic [DATA_WIDTH-1:0]          m_pwdata,
   output logic [STRB_WIDTH-1:0]          m_pstrb,
   input  logic [DATA_WIDTH-1:0]          m_prdata,
   input  logic                           m_pready,
   input  logic                           m_pslverr
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  last_grant;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  winner;
   logic              any_valid;
   logic              accept;
   logic              timeout_hit;
   logic [CNT_W-1:0]  wait_cnt;
   int unsigned       scan_idx;

   // Scan downward so the smallest offset from last_grant is the last to assign, i.e. wins.
   always_comb begin
      winner    = last_grant;
      any_valid = 1'b0;
      scan_idx  = 0;
      for (int unsigned i = NUM_REQ; i >= 1; i--) begin
         scan_idx = (32'(last_grant) + i) % NUM_REQ;
         if (req_valid[scan_idx]) begin
            winner    = IDX_W'(scan_idx);
            any_valid = 1'b1;
         end
      end
   end

   assign accept      = (state == IDLE) && any_valid;
   assign timeout_hit = (TIMEOUT > 0) && !m_pready && (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (m_pready || timeout_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
      m_psel    = (state != IDLE);
      m_penable = (state == ACCESS);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_grant  <= IDX_W'(NUM_REQ - 1);
         owner       <= '0;
         m_pwrite    <= 1'b0;
         m_paddr     <= '0;
         m_pwdata    <= '0;
         m_pstrb     <= '0;
         wait_cnt    <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (accept) begin
            owner      <= winner;
            last_grant <= winner;
            m_pwrite   <= req_write[winner];
            m_paddr    <= req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            m_pwdata   <= req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            m_pstrb    <= req_write[winner] ? req_strb[winner*STRB_WIDTH +: STRB_WIDTH] : '0;
         end
         if (state == SETUP) wait_cnt <= '0;
         if (state == ACCESS) begin
            if (m_pready) begin
               rsp_valid[owner] <= 1'b1;
               rsp_rdata        <= m_pwrite ? '0 : m_prdata;
               rsp_err          <= m_pslverr;
               rsp_timeout      <= 1'b0;
            end else if (timeout_hit) begin
               rsp_valid[owner] <= 1'b1;
               rsp_rdata        <= '0;
               rsp_err          <= 1'b1;
               rsp_timeout      <= 1'b1;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Bench for apb_rr_master_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-level model that tracks cycles elapsed since each accept.
module tb_apb_rr_master_arbiter;

   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_write = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*DW-1:0]  req_wdata = '0;
   logic [NR*SW-1:0]  req_strb = '0;
   logic [NR-1:0]     rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              m_psel;
   logic              m_penable;
   logic              m_pwrite;
   logic [AW-1:0]     m_paddr;
   logic [DW-1:0]     m_pwdata;
   logic [SW-1:0]     m_pstrb;
   logic [DW-1:0]     m_prdata = '0;
   logic              m_pready = 1'b1;
   logic              m_pslverr = 1'b0;

   int pass_cnt = 0;
   int total_cnt = 0;

   apb_rr_master_arbiter #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
      .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_prdata(m_prdata), .m_pready(m_pready),
      .m_pslverr(m_pslverr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a transfer is "in flight" for phase=1 (setup) and phase>=2 (access) cycles after its accept.
   int             md_busy = 0;
   int             md_phase = 0;
   int             md_owner = 0;
   int             md_waits = 0;
   int             md_last = NR - 1;
   int             md_pend = -1;
   logic [AW-1:0]  md_addr = '0;
   logic [DW-1:0]  md_wdata = '0;
   logic [SW-1:0]  md_strb = '0;
   logic           md_write = 1'b0;
   logic [DW-1:0]  md_rdata = '0;
   logic           md_err = 1'b0;
   logic           md_to = 1'b0;

   always @(negedge clk) begin
      int g;
      logic [NR-1:0] e_ready;
      logic [NR-1:0] e_rsp;
      if (!rstn) begin
         md_busy = 0; md_phase = 0; md_owner = 0; md_waits = 0; md_last = NR - 1; md_pend = -1;
         md_addr = '0; md_wdata = '0; md_strb = '0; md_write = 1'b0;
         md_rdata = '0; md_err = 1'b0; md_to = 1'b0;
         check("rst_psel", 64'(m_psel), 64'(0));
         check("rst_penable", 64'(m_penable), 64'(0));
         check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      end else begin
         g = -1;
         if (md_busy == 0)
            for (int k = 1; k <= NR; k++)
               if (g < 0 && req_valid[(md_last + k) % NR]) g = (md_last + k) % NR;
         e_ready = '0;
         if (g >= 0) e_ready[g] = 1'b1;
         e_rsp = '0;
         if (md_pend >= 0) e_rsp[md_pend] = 1'b1;
         check("req_ready", 64'(req_ready), 64'(e_ready));
         check("psel", 64'(m_psel), 64'(md_busy != 0));
         check("penable", 64'(m_penable), 64'(md_busy != 0 && md_phase >= 2));
         check("paddr", 64'(m_paddr), 64'(md_addr));
         check("pwrite", 64'(m_pwrite), 64'(md_write));
         check("pwdata", 64'(m_pwdata), 64'(md_wdata));
         check("pstrb", 64'(m_pstrb), 64'(md_strb));
         check("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
         check("rsp_rdata", 64'(rsp_rdata), 64'(md_rdata));
         check("rsp_err", 64'(rsp_err), 64'(md_err));
         check("rsp_timeout", 64'(rsp_timeout), 64'(md_to));
         md_pend = -1;
         if (md_busy == 0) begin
            if (g >= 0) begin
               md_busy  = 1; md_phase = 1; md_owner = g; md_last = g;
               md_write = req_write[g];
               md_addr  = req_addr[g*AW +: AW];
               md_wdata = req_wdata[g*DW +: DW];
               md_strb  = req_write[g] ? req_strb[g*SW +: SW] : '0;
            end
         end else if (md_phase == 1) begin
            md_phase = 2; md_waits = 0;
         end else if (m_pready) begin
            md_busy = 0; md_pend = md_owner;
            md_rdata = md_write ? '0 : m_prdata;
            md_err = m_pslverr; md_to = 1'b0;
         end else if (TO > 0 && md_waits + 1 == TO) begin
            md_busy = 0; md_pend = md_owner;
            md_rdata = '0; md_err = 1'b1; md_to = 1'b1;
         end else begin
            md_waits++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic set_req(input int r, input logic v, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_valid[r] = v;
      req_write[r] = w;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
      req_strb[r*SW +: SW] = s;
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      repeat (n) step();
   endtask

   task automatic do_reset();
      step();
      req_valid = '0; m_pready = 1'b1; m_pslverr = 1'b0;
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask

   initial begin
      int acc;
      int last_c;
      int idx;
      int naccess;
      bit seen;

      // reset state
      repeat (3) step();
      rstn = 1'b1;
      at_neg();
      check("t0_psel", 64'(m_psel), 64'(0));
      check("t0_rsp_valid", 64'(rsp_valid), 64'(0));

      // 1: single write from requester 0
      step();
      set_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5, 4'hF);
      m_pready = 1'b1;
      at_neg();
      check("t1_ready", 64'(req_ready), 64'(3'b001));
      step();
      req_valid = '0;
      at_neg();
      check("t1_setup_psel", 64'(m_psel), 64'(1));
      check("t1_setup_penable", 64'(m_penable), 64'(0));
      check("t1_paddr", 64'(m_paddr), 64'(32'h10));
      check("t1_pstrb", 64'(m_pstrb), 64'(4'hF));
      step();
      at_neg();
      check("t1_access_penable", 64'(m_penable), 64'(1));
      step();
      at_neg();
      check("t1_rsp_valid", 64'(rsp_valid), 64'(3'b001));
      check("t1_rsp_err", 64'(rsp_err), 64'(0));

      // 2: two requesters held valid, alternating grants every 3 cycles
      do_reset();
      set_req(0, 1'b1, 1'b1, 32'h100, 32'h1, 4'h3);
      set_req(1, 1'b1, 1'b0, 32'h200, 32'h2, 4'hC);
      acc = 0;
      last_c = -1;
      for (int c = 0; c < 40 && acc < 6; c++) begin
         at_neg();
         if (req_ready != '0) begin
            idx = (req_ready == 3'b001) ? 0 : (req_ready == 3'b010) ? 1 : 99;
            check("t2_grant", 64'(idx), 64'(acc % 2));
            if (acc > 0) check("t2_gap", 64'(c - last_c), 64'(3));
            last_c = c;
            acc++;
         end
         step();
         if (acc == 6) req_valid = '0;
      end
      check("t2_count", 64'(acc), 64'(6));
      idle(4);

      // 3: read with 3 wait states
      set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
      m_pready = 1'b0;
      at_neg();
      check("t3_ready", 64'(req_ready), 64'(3'b010));
      step();
      req_valid = '0;
      at_neg();
      check("t3_setup_paddr", 64'(m_paddr), 64'(32'h20));
      for (int a = 0; a < 4; a++) begin
         step();
         if (a == 3) begin
            m_pready = 1'b1;
            m_prdata = 32'hDEADBEEF;
         end
         at_neg();
         check("t3_access_paddr", 64'(m_paddr), 64'(32'h20));
         check("t3_access_penable", 64'(m_penable), 64'(1));
         check("t3_pstrb_read", 64'(m_pstrb), 64'(0));
      end
      step();
      at_neg();
      check("t3_rsp_valid", 64'(rsp_valid), 64'(3'b010));
      check("t3_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
      idle(2);

      // 4: slave never ready -> timeout after exactly TO access cycles
      set_req(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
      m_pready = 1'b0;
      step();
      req_valid = '0;
      naccess = 0;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         at_neg();
         if (m_psel && m_penable) naccess++;
         if (rsp_valid != '0) begin
            seen = 1'b1;
            check("t4_rsp_owner", 64'(rsp_valid), 64'(3'b001));
            check("t4_err", 64'(rsp_err), 64'(1));
            check("t4_timeout", 64'(rsp_timeout), 64'(1));
            check("t4_rdata", 64'(rsp_rdata), 64'(0));
         end
         step();
      end
      check("t4_rsp_seen", 64'(seen), 64'(1));
      check("t4_access_cycles", 64'(naccess), 64'(TO));
      m_pready = 1'b1;
      idle(2);

      // 5: slave error on a write, then a clean write
      set_req(1, 1'b1, 1'b1, 32'h30, 32'h5, 4'h1);
      m_pslverr = 1'b1;
      step();
      req_valid = '0;
      step();
      step();
      at_neg();
      check("t5_rsp_valid", 64'(rsp_valid), 64'(3'b010));
      check("t5_err", 64'(rsp_err), 64'(1));
      check("t5_timeout", 64'(rsp_timeout), 64'(0));
      m_pslverr = 1'b0;
      set_req(0, 1'b1, 1'b1, 32'h34, 32'h6, 4'h2);
      step();
      req_valid = '0;
      step();
      step();
      at_neg();
      check("t5_next_rsp", 64'(rsp_valid), 64'(3'b001));
      check("t5_next_err", 64'(rsp_err), 64'(0));
      idle(2);

      // 6: reset during ACCESS
      set_req(2, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
      m_pready = 1'b0;
      step();
      req_valid = '0;
      step();
      at_neg();
      check("t6_in_access", 64'(m_penable), 64'(1));
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("t6_async_psel", 64'(m_psel), 64'(0));
      check("t6_async_penable", 64'(m_penable), 64'(0));
      m_pready = 1'b1;
      step();
      step();
      rstn = 1'b1;
      set_req(0, 1'b1, 1'b1, 32'h60, 32'h7, 4'hF);
      set_req(2, 1'b1, 1'b1, 32'h64, 32'h8, 4'hF);
      at_neg();
      check("t6_no_rsp", 64'(rsp_valid), 64'(0));
      check("t6_req0_first", 64'(req_ready), 64'(3'b001));
      idle(4);

      // random traffic, with periodic hung-slave windows to force timeouts
      for (int c = 0; c < 3000; c++) begin
         for (int r = 0; r < NR; r++)
            set_req(r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    4'($urandom_range(0, 15)));
         m_pready  = ((c % 600) >= 570) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
         m_pslverr = 1'($urandom_range(0, 7) == 0);
         m_prdata  = $urandom;
         step();
      end
      idle(30);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
